fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions: fetch FSM encoding, reset/exception vectors, and PC
// alignment. The decode exception path uses the same vector constants.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_TRAP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;

    // Instruction fetches are always word-aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Non-speculative instruction fetch: one request in flight, the fetched word is
// held for decode until consumed, and illegal instructions redirect to EXC_VECTOR.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  i_fetch,
    output logic [31:0]  pc,
    output logic         fetch_valid,
    input  logic         decode_ready,
    input  logic [31:0]  next_pc,
    input  logic         is_illegal,
    output fetch_state_e dbg_state
);

    // Handshakes: a memory request is accepted in any cycle where imem_req and
    // imem_gnt are both high; an instruction is consumed in any cycle where
    // fetch_valid and decode_ready are both high. Inputs tied to a transfer are
    // ignored in all other cycles.

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         started_q;

    // started_q keeps imem_req low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_REQ;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            started_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        imem_req    = 1'b0;
        fetch_valid = 1'b0;
        case (state_q)
            ST_REQ: begin
                imem_req = started_q;
                if (started_q && imem_gnt) begin
                    if (imem_rvalid) begin
                        instr_d = imem_rdata;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                fetch_valid = 1'b1;
                if (decode_ready) begin
                    if (is_illegal) begin
                        state_d = ST_TRAP;
                    end else begin
                        pc_d    = word_align(next_pc);
                        state_d = ST_REQ;
                    end
                end
            end
            ST_TRAP: begin
                pc_d    = word_align(EXC_VECTOR);
                state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign i_fetch   = instr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the bench plays instruction memory and decode,
// with hand-computed addresses, data and cycle timing.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_gnt;
    logic         imem_rvalid;
    logic [31:0]  imem_rdata;
    logic [31:0]  i_fetch;
    logic [31:0]  pc;
    logic         fetch_valid;
    logic         decode_ready;
    logic [31:0]  next_pc;
    logic         is_illegal;
    fetch_state_e dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .i_fetch      (i_fetch),
        .pc           (pc),
        .fetch_valid  (fetch_valid),
        .decode_ready (decode_ready),
        .next_pc      (next_pc),
        .is_illegal   (is_illegal),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for imem_req at a falling edge; returns with it seen.
    task automatic wait_req();
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("req_timeout", 32'(imem_req), 32'h1);
    endtask

    // One full instruction: request, optional wait states, optional decode
    // stall, then handshake. Returns at the falling edge one cycle after the
    // handshake (or after the trap cycle for an illegal instruction).
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data,
                             input int wait_n, input int hold_n,
                             input logic [31:0] npc, input logic illegal);
        wait_req();
        check("req_addr", imem_addr, addr);
        exp_q.push_back(data);
        imem_gnt = 1'b1;
        if (wait_n == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = data;
            @(negedge clk);
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
        end else begin
            @(negedge clk);
            imem_gnt = 1'b0;
            for (int i = 1; i < wait_n; i++) begin
                check("wait_req_low", 32'(imem_req), 32'h0);
                check("wait_valid_low", 32'(fetch_valid), 32'h0);
                @(negedge clk);
            end
            imem_rvalid = 1'b1;
            imem_rdata  = data;
            @(negedge clk);
            imem_rvalid = 1'b0;
        end
        check("hold_valid", 32'(fetch_valid), 32'h1);
        check("hold_instr", i_fetch, exp_q.pop_front());
        check("hold_pc", pc, addr);
        for (int i = 0; i < hold_n; i++) begin
            decode_ready = 1'b0;
            next_pc      = $urandom_range(32'h7fff_ffff, 0);
            is_illegal   = 1'b1;
            imem_rvalid  = 1'b1;
            imem_rdata   = ~data;
            @(negedge clk);
            check("stall_instr", i_fetch, data);
            check("stall_pc", pc, addr);
            check("stall_req_low", 32'(imem_req), 32'h0);
            check("stall_valid", 32'(fetch_valid), 32'h1);
        end
        imem_rvalid  = 1'b0;
        decode_ready = 1'b1;
        next_pc      = npc;
        is_illegal   = illegal;
        @(negedge clk);
        decode_ready = 1'b0;
        is_illegal   = 1'b0;
        next_pc      = 32'hdead_beef;
        if (illegal) begin
            check("trap_state", 32'(dbg_state), 32'(ST_TRAP));
            check("trap_req_low", 32'(imem_req), 32'h0);
            check("trap_valid_low", 32'(fetch_valid), 32'h0);
            @(negedge clk);
            check("trap_next_req", 32'(imem_req), 32'h1);
            check("trap_addr", imem_addr, 32'h0000_0080);
        end else begin
            check("next_req", 32'(imem_req), 32'h1);
            check("next_addr", imem_addr, {npc[31:2], 2'b00});
            check("next_valid_low", 32'(fetch_valid), 32'h0);
        end
    endtask

    initial begin
        rst_n        = 1'b1;
        imem_gnt     = 1'b1;
        imem_rvalid  = 1'b1;
        imem_rdata   = 32'h1111_1111;
        decode_ready = 1'b1;
        next_pc      = 32'h0;
        is_illegal   = 1'b0;
        #1 rst_n = 1'b0;

        // reset: outputs quiet even with zero-wait memory and a ready decode
        repeat (3) begin
            @(negedge clk);
            check("rst_req", 32'(imem_req), 32'h0);
            check("rst_valid", 32'(fetch_valid), 32'h0);
            check("rst_pc", pc, 32'h0);
            check("rst_instr", i_fetch, 32'h0);
            check("rst_state", 32'(dbg_state), 32'(ST_REQ));
        end
        rst_n = 1'b1;
        #1 check("rel_req_before_edge", 32'(imem_req), 32'h0);
        @(negedge clk);
        check("first_req", 32'(imem_req), 32'h1);
        check("first_addr", imem_addr, 32'h0);
        check("first_valid", 32'(fetch_valid), 32'h0);
        imem_gnt     = 1'b0;
        imem_rvalid  = 1'b0;
        decode_ready = 1'b0;

        // sequential zero-wait
        fetch_one(32'h0000_0000, 32'hA000_0001, 0, 0, 32'h0000_0004, 1'b0);
        fetch_one(32'h0000_0004, 32'hA000_0002, 0, 0, 32'h0000_0008, 1'b0);
        fetch_one(32'h0000_0008, 32'hA000_0003, 0, 0, 32'h0000_000C, 1'b0);
        // wait states
        fetch_one(32'h0000_000C, 32'hB0B0_0004, 4, 0, 32'h0000_0010, 1'b0);
        // backpressure, then branch to an unaligned target
        fetch_one(32'h0000_0010, 32'hC0C0_0005, 0, 5, 32'h1234_5676, 1'b0);
        fetch_one(32'h1234_5674, 32'hD0D0_0006, 1, 0, 32'h0000_0040, 1'b0);
        // illegal instruction at 0x40 traps to 0x80
        fetch_one(32'h0000_0040, 32'hDEAD_0007, 0, 0, 32'h0000_0044, 1'b1);
        // wrap at 32 bits
        fetch_one(32'h0000_0080, 32'hE0E0_0008, 0, 0, 32'hFFFF_FFFF, 1'b0);
        fetch_one(32'hFFFF_FFFC, 32'hF0F0_0009, 2, 0, 32'hFFFF_FFFC + 32'd4, 1'b0);

        // reset asserted mid-WAIT abandons the transaction
        wait_req();
        check("abort_addr", imem_addr, 32'h0000_0000);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        check("abort_in_wait", 32'(dbg_state), 32'(ST_WAIT));
        #2 rst_n = 1'b0;
        #1 check("abort_req_low", 32'(imem_req), 32'h0);
        check("abort_state", 32'(dbg_state), 32'(ST_REQ));
        @(negedge clk);
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h5A5A_5A5A;
        @(negedge clk);
        imem_rvalid = 1'b1;
        check("late_rvalid_state", 32'(dbg_state), 32'(ST_REQ));
        check("late_rvalid_req", 32'(imem_req), 32'h1);
        check("late_rvalid_addr", imem_addr, 32'h0);
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("rvalid_no_gnt_state", 32'(dbg_state), 32'(ST_REQ));
        check("rvalid_no_gnt_valid", 32'(fetch_valid), 32'h0);
        check("rvalid_no_gnt_instr", i_fetch, 32'h0);
        fetch_one(32'h0000_0000, 32'h1357_9BDF, 0, 0, 32'h0000_0004, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
